// File: rtl/voice_scheduler_if.sv
// Lookup bus between the voice scheduler and the combinational audio_rom.
// The scheduler registers index/freq_id; the lookup answers within the same cycle.
interface voice_scheduler_if #(
  parameter int BITS = 6
);
  logic [10:0]     rom_index;
  logic [4:0]      rom_freq_id;
  logic [BITS-1:0] rom_level;
  logic [10:0]     rom_freq;

  modport master (
    output rom_index,
    output rom_freq_id,
    input  rom_level,
    input  rom_freq
  );

  modport slave (
    input  rom_index,
    input  rom_freq_id,
    output rom_level,
    output rom_freq
  );
endinterface

// File: rtl/voice_scheduler.sv
// Time-multiplexes one sine/frequency lookup across VOICES tone voices and mixes
// their levels into one sample per sample_tick; note changes latch only at phase wrap.
module voice_scheduler #(
  parameter  int VOICES = 4,
  parameter  int BITS   = 6,
  localparam int SW     = BITS + $clog2(VOICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [5*VOICES-1:0]   note_id,
  input  logic [VOICES-1:0]     note_on,
  voice_scheduler_if.master     rom,
  output logic [SW-1:0]         sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int             VCW       = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [VCW-1:0] VC_LAST   = VCW'(VOICES - 1);
  localparam logic [4:0]     SILENT_ID = 5'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [VCW-1:0]  vc_r;
  logic [SW-1:0]   acc_r;
  logic [15:0]     phase_r     [VOICES];
  logic [4:0]      active_id_r [VOICES];
  logic [4:0]      note_arr_s  [VOICES];
  logic [4:0]      req_id_s;
  logic [16:0]     sum_s;
  logic            latch_s;
  logic [15:0]     phase_nxt_s;

  // Unpack the flat per-voice note request bus
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      note_arr_s[v] = note_id[5*v +: 5];
    end
  end

  // Phase advance and note latch decision for the voice in its capture slot
  always_comb begin
    req_id_s = note_on[vc_r] ? note_arr_s[vc_r] : SILENT_ID;
    sum_s    = {1'b0, phase_r[vc_r]} + {6'd0, rom.rom_freq};
    latch_s  = sum_s[16] || (active_id_r[vc_r] == SILENT_ID);
    // A note-off restarts the voice at a zero crossing so a later note-on starts cleanly
    if (latch_s && (req_id_s == SILENT_ID)) begin
      phase_nxt_s = 16'd0;
    end else begin
      phase_nxt_s = sum_s[15:0];
    end
  end

  // Next-state logic of the sample sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sample_tick) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = CAPTURE;
      end
      CAPTURE: begin
        if (vc_r == VC_LAST) begin
          state_s = DONE;
        end else begin
          state_s = ISSUE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Voice state, lookup drive, accumulator and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      vc_r            <= {VCW{1'b0}};
      acc_r           <= {SW{1'b0}};
      for (int v = 0; v < VOICES; v++) begin
        phase_r[v]     <= 16'd0;
        active_id_r[v] <= SILENT_ID;
      end
      rom.rom_index   <= 11'd0;
      rom.rom_freq_id <= SILENT_ID;
      sample_out      <= {SW{1'b0}};
      sample_valid    <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      sample_valid <= (state_r == DONE);
      busy         <= (state_s != IDLE);
      // Ticks arriving while a sample is in flight are dropped and flagged
      overrun      <= sample_tick && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (sample_tick) begin
            acc_r <= {SW{1'b0}};
            vc_r  <= {VCW{1'b0}};
          end
        end
        ISSUE: begin
          rom.rom_index   <= {1'b0, phase_r[vc_r][15:6]};
          rom.rom_freq_id <= active_id_r[vc_r];
        end
        CAPTURE: begin
          acc_r         <= acc_r + SW'(rom.rom_level);
          phase_r[vc_r] <= phase_nxt_s;
          if (latch_s) begin
            active_id_r[vc_r] <= req_id_s;
          end
          if (vc_r != VC_LAST) begin
            vc_r <= vc_r + VCW'(1);
          end
        end
        DONE: begin
          sample_out <= acc_r;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: a sine/frequency lookup model plus a
// per-sample reference of the voice mixer, directed scenarios then random notes.
module tb_voice_scheduler;

  localparam int  VOICES = 4;
  localparam int  BITS   = 6;
  localparam int  SW     = BITS + $clog2(VOICES);
  localparam int  NK     = 2*VOICES + 4;
  localparam real PI     = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sample_tick;
  logic [5*VOICES-1:0]  note_id;
  logic [VOICES-1:0]    note_on;
  logic [SW-1:0]        sample_out;
  logic                 sample_valid;
  logic                 busy;
  logic                 overrun;

  logic [BITS-1:0] lvl_tab [2048];
  logic [10:0]     frq_tab [32];

  voice_scheduler_if #(.BITS(BITS)) rom_bus ();

  // Combinational lookup model answering the registered index/freq_id
  assign rom_bus.rom_level = lvl_tab[rom_bus.rom_index];
  assign rom_bus.rom_freq  = frq_tab[rom_bus.rom_freq_id];

  voice_scheduler #(.VOICES(VOICES), .BITS(BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .note_id      (note_id),
    .note_on      (note_on),
    .rom          (rom_bus),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int mph  [VOICES];
  int mact [VOICES];
  int v0_fid;
  int exp_v0_fid;
  int max_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out"},     32'(sample_out), 32'd0);
    chk({tag, "_valid"},   32'(sample_valid), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_index"},   32'(rom_bus.rom_index), 32'd0);
    chk({tag, "_fid"},     32'(rom_bus.rom_freq_id), 32'd31);
  endtask

  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      mph[v]  = 0;
      mact[v] = 31;
    end
  endtask

  // One mixed sample from the voice rules: level at current phase, then advance/latch
  task automatic model_sample(output int sum);
    int nxt;
    int req;
    bit carry;
    sum        = 0;
    exp_v0_fid = mact[0];
    for (int v = 0; v < VOICES; v++) begin
      sum   += int'(lvl_tab[mph[v] / 64]);
      nxt    = mph[v] + int'(frq_tab[mact[v]]);
      carry  = (nxt >= 65536);
      if (carry) nxt -= 65536;
      req = note_on[v] ? int'(note_id[5*v +: 5]) : 31;
      if (carry || mact[v] == 31) begin
        mact[v] = req;
        if (req == 31) nxt = 0;
      end
      mph[v] = nxt;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    model_reset();
  endtask

  // One tick with cycle-by-cycle checks; optional extra tick at inj_k or reset at rst_k
  task automatic do_sample(input int inj_k, input int rst_k);
    int exp_sum;
    bit abort;
    exp_sum = 0;
    abort   = (rst_k > 0);
    if (abort) model_reset();
    else       model_sample(exp_sum);
    @(negedge clk);
    sample_tick = 1'b1;
    for (int k = 1; k <= NK; k++) begin
      @(negedge clk);
      if (k == 1) sample_tick = 1'b0;
      if (abort && k > rst_k) begin
        if (k == rst_k + 1) begin
          chk_reset_vals("abort");
          reset = 1'b0;
        end
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_valid", 32'(sample_valid), 32'd0);
      end else begin
        chk("busy",    32'(busy), 32'(k <= 2*VOICES + 1));
        chk("valid",   32'(sample_valid), 32'(k == 2*VOICES + 2));
        chk("overrun", 32'(overrun), 32'(inj_k > 0 && k == inj_k + 1));
        if (k == 2 && !abort) begin
          v0_fid = int'(rom_bus.rom_freq_id);
          chk("v0_fid", 32'(v0_fid), 32'(exp_v0_fid));
        end
        if (k >= 2*VOICES + 2) chk("sample_out", 32'(sample_out), 32'(exp_sum));
      end
      if (inj_k > 0 && k == inj_k)     sample_tick = 1'b1;
      if (inj_k > 0 && k == inj_k + 1) sample_tick = 1'b0;
      if (abort && k == rst_k)         reset = 1'b1;
    end
    if (!abort && int'(sample_out) > max_out) max_out = int'(sample_out);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    real s;
    real f;
    int  exp_out [4];
    int  exp_ph  [4];
    int  r;

    for (int i = 0; i < 2048; i++) begin
      if (i < 1024) begin
        s = $sin(2.0 * PI * i / 1024.0);
        if (s < 0.0) s = -s;
        lvl_tab[i] = BITS'($rtoi(768.0 * s + 0.5) >>> (10 - BITS));
      end else begin
        lvl_tab[i] = '0;
      end
    end
    f = 135.0;
    for (int id = 0; id < 32; id++) begin
      frq_tab[id] = (id <= 24) ? 11'($rtoi(f + 0.5)) : 11'd0;
      f = f * 1.0594630943592953;
    end

    reset       = 1'b1;
    sample_tick = 1'b0;
    note_id     = '0;
    note_on     = '0;
    max_out     = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("init");
    reset = 1'b0;
    model_reset();

    // All voices off: silent sample, phases stay at zero
    do_sample(0, 0);
    for (int v = 0; v < VOICES; v++) chk("silent_phase", 32'(dut.phase_r[v]), 32'd0);

    // Voice 0 on id 12 (freq 270): first sample only latches the note
    note_on = 4'b0001;
    note_id = {15'd0, 5'd12};
    exp_out = '{0, 0, 1, 2};
    exp_ph  = '{0, 270, 540, 810};
    for (int n = 0; n < 4; n++) begin
      do_sample(0, 0);
      chk("id12_out",   32'(sample_out), 32'(exp_out[n]));
      chk("id12_phase", 32'(dut.phase_r[0]), 32'(exp_ph[n]));
      idle(6);
    end

    // Voice 0 on id 0: a change to id 24 waits for the phase wrap
    do_reset();
    note_id = {15'd0, 5'd0};
    for (int n = 1; n <= 490; n++) begin
      if (n == 100) note_id = {15'd0, 5'd24};
      do_sample(0, 0);
      if (n == 300) chk("pre_wrap_fid", 32'(v0_fid), 32'd0);
      if (n == 488) chk("post_wrap_fid", 32'(v0_fid), 32'd24);
    end

    // All voices id 11 through the peak: mix reaches 4*48 without overflow
    do_reset();
    note_on = 4'hf;
    note_id = {4{5'd11}};
    max_out = 0;
    for (int n = 0; n < 75; n++) do_sample(0, 0);
    chk("peak_mix", 32'(max_out), 32'd192);

    // Tick during a sample is dropped and flagged
    do_sample(3, 0);
    // Reset mid-sample aborts it; the next tick completes normally
    do_sample(0, 5);
    do_sample(0, 0);

    // Random notes and gates with random tick spacing
    for (int n = 0; n < 40; n++) begin
      for (int v = 0; v < VOICES; v++) begin
        r = int'($urandom_range(0, 25));
        note_id[5*v +: 5] = (r == 25) ? 5'd31 : 5'(r);
      end
      note_on = 4'($urandom);
      do_sample(0, 0);
      idle(int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Time-multiplexes the single combinational sine/frequency lookup (the `audio_rom` block) among `VOICES` independent tone voices. On each audio sample strobe, the block does three things for every voice in turn:
- walks that voice's 16-bit phase accumulator through the lookup;
- sums the returned levels into one mixed sample;
- advances each phase by the per-note increment the lookup returns.

Note changes and note-offs take effect only at a voice's phase wrap, so the output never steps mid-cycle. The block sits between the keyboard/note-input logic and the audio DAC/PWM stage.

## Interface
Parameters:
- `VOICES`, 4: number of voices; power of two, 1–8
- `BITS`, 6: lookup level width; must match the lookup's `BITS`
- `SW`, `BITS+$clog2(VOICES)` (localparam): mixed sample width

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `sample_tick` in 1: one-cycle strobe requesting one mixed sample
- `note_id` in `5*VOICES`: requested freq_id per voice; voice v uses `[5v+4:5v]`; values 25–30 are illegal
- `note_on` in `VOICES`: per-voice gate
- `rom_index` out 11: index driven to the lookup
- `rom_freq_id` out 5: freq_id driven to the lookup
- `rom_level` in `BITS`: level returned by the lookup
- `rom_freq` in 11: phase increment returned by the lookup
- `sample_out` out `SW`: mixed sample
- `sample_valid` out 1: one-cycle pulse when `sample_out` updates
- `busy` out 1: high while a sample is in progress
- `overrun` out 1: one-cycle pulse when a tick is dropped

## Operation
- Per-voice state:
  - `phase[v]`, 16 bits
  - `active_id[v]`, 5 bits; 31 = silent (lookup returns freq 0)
- Effective request for voice v: `req_id = note_on[v] ? note_id[v] : 31`.
- States: IDLE, ISSUE, CAPTURE, DONE. Voice counter `vc` is `$clog2(VOICES)` bits.
- IDLE:
  - on `sample_tick`: clear accumulator `acc`, set `vc = 0`, go to ISSUE
  - otherwise stay in IDLE
- ISSUE:
  - register `rom_index = {1'b0, phase[vc][15:6]}` (range 0–1023)
  - register `rom_freq_id = active_id[vc]`
  - go to CAPTURE
- CAPTURE (lookup outputs are valid this cycle, since the lookup is combinational on registered inputs):
  - `acc += rom_level`
  - `{carry, nxt} = phase[vc] + rom_freq`, computed at 17 bits
  - `phase[vc] = nxt`
  - if `carry` or `active_id[vc] == 31`: `active_id[vc] = req_id`
  - if `req_id == 31` and the latch occurs: also force `phase[vc] = 0`, so the voice restarts from a zero crossing
  - if `vc == VOICES-1`: go to DONE; otherwise `vc++` and go to ISSUE
- DONE:
  - `sample_out = acc`
  - pulse `sample_valid`
  - go to IDLE
- Width rule: `acc` is `SW` bits. The maximum sum `VOICES*(768>>(10-BITS))` fits in `SW`, so there is no saturation logic.
- A silent voice still takes its ISSUE/CAPTURE slot. It contributes the level at its frozen phase, which is 0 because phase is forced to 0 on note-off.
- `busy` = (state != IDLE).
- `sample_tick` while `busy`:
  - the tick is ignored
  - `overrun` pulses on the following cycle
  - the sample in progress is unaffected
- `note_id` and `note_on` are sampled only during CAPTURE of the corresponding voice. Changes at other times have no effect until then.
- Reset values:
  - state IDLE, `vc = 0`, `acc = 0`
  - all `phase = 0`, all `active_id = 31`
  - `rom_index = 0`, `rom_freq_id = 31`
  - `sample_out = 0`
  - `sample_valid`, `busy`, `overrun` all 0
- Reset asserted mid-sample aborts it; no `sample_valid` is produced.

## Timing
- Tick sampled in cycle T:
  - ISSUE for voice v at T+1+2v
  - CAPTURE for voice v at T+2+2v
  - DONE at T+2·VOICES+1
- `sample_valid` and the new `sample_out` are visible in cycle T+2·VOICES+2. For VOICES=4 that is T+10.
- `busy` is high from T+1 through T+2·VOICES+1.
- Minimum accepted tick spacing: 2·VOICES+2 cycles.
- `sample_out` holds its value between pulses.
- Note latency: a note change takes effect from the first sample after the voice's next wrap, or on the next sample if the voice is silent.

## Test plan
- Reset, then a single tick with all `note_on = 0`: `sample_valid` pulses once at T+10 with `sample_out = 0`; all phases remain 0.
- Voice 0 on with id 12 (freq 270), BITS=6, ticks every 20 cycles:
  - `sample_out` sequence is 0 (phase 0), then 1 (index 4, value 19), then 2 (index 8, value 38)
  - `phase[0]` reads 270, 540, 810
- Voice 0 on with id 0 (freq 135): first wrap occurs on the 486th sample. Changing `note_id` to 24 at sample 100 leaves `rom_freq_id = 0` until after the wrap, then 24.
- All 4 voices on with id 11, run to index 256 (peak): `sample_out = 4*48 = 192`, with no overflow.
- Tick asserted at T+3 during a sample: `overrun` pulses at T+4; exactly one `sample_valid` occurs, at T+10.
- Reset asserted at T+5 mid-sample: no `sample_valid`; all outputs return to reset values the next cycle; a tick after reset completes normally.
